// File: rtl/alu_seq.sv
// alu_seq: sequencer that drives an external combinational ALU over a 4 x 8-bit
// register file. Commands are handled one at a time through IDLE -> (EXEC) -> RESP.
// Optional feature: define ALU_SEQ_FLAGS_EN to add rsp_zero / rsp_carry outputs.
module alu_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [1:0] cmd_dst,
  input  logic [1:0] cmd_sa,
  input  logic [1:0] cmd_sb,
  input  logic [7:0] cmd_imm,
  output logic [2:0] alu_opcode,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  input  logic [7:0] alu_out,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
`ifdef ALU_SEQ_FLAGS_EN
  output logic       rsp_zero,
  output logic       rsp_carry,
`endif
  input  logic       rsp_ready
);

  localparam logic [2:0] OpPlus  = 3'd0;
  localparam logic [2:0] OpMinus = 3'd1;
  localparam logic [2:0] OpLoad  = 3'd5;
  localparam logic [2:0] OpRead  = 3'd6;
  localparam logic [2:0] OpRsvd  = 3'd7;

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e     state_q;
  logic [7:0] regs_q [4];
  logic [1:0] dst_q;

`ifdef ALU_SEQ_FLAGS_EN
  // Carry/borrow taken from the operands actually presented to the ALU.
  logic [8:0] sum9;
  logic       carry_d;
  always_comb begin
    sum9    = {1'b0, alu_a} + {1'b0, alu_b};
    carry_d = 1'b0;
    if (alu_opcode == OpPlus)  carry_d = sum9[8];
    if (alu_opcode == OpMinus) carry_d = (alu_a < alu_b);
  end
`endif

  // Handshake outputs follow the state register directly.
  assign cmd_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StResp);

  // FSM, register file and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      for (int i = 0; i < 4; i++) regs_q[i] <= 8'h00;
      dst_q      <= 2'd0;
      alu_opcode <= 3'd0;
      alu_a      <= 8'h00;
      alu_b      <= 8'h00;
      rsp_data   <= 8'h00;
      rsp_err    <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
      rsp_zero   <= 1'b0;
      rsp_carry  <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            dst_q <= cmd_dst;
            if (cmd_op == OpLoad) begin
              regs_q[cmd_dst] <= cmd_imm;
              rsp_data        <= cmd_imm;
              rsp_err         <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
              rsp_zero        <= (cmd_imm == 8'h00);
              rsp_carry       <= 1'b0;
`endif
              state_q         <= StResp;
            end else if (cmd_op == OpRead) begin
              rsp_data  <= regs_q[cmd_sa];
              rsp_err   <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
              rsp_zero  <= (regs_q[cmd_sa] == 8'h00);
              rsp_carry <= 1'b0;
`endif
              state_q   <= StResp;
            end else if (cmd_op == OpRsvd) begin
              rsp_data  <= 8'h00;
              rsp_err   <= 1'b1;
`ifdef ALU_SEQ_FLAGS_EN
              rsp_zero  <= 1'b0;
              rsp_carry <= 1'b0;
`endif
              state_q   <= StResp;
            end else begin
              // Operands sampled here, so sa/sb == dst reads the old value.
              alu_opcode <= cmd_op;
              alu_a      <= regs_q[cmd_sa];
              alu_b      <= regs_q[cmd_sb];
              state_q    <= StExec;
            end
          end
        end
        StExec: begin
          regs_q[dst_q] <= alu_out;
          rsp_data      <= alu_out;
          rsp_err       <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
          rsp_zero      <= (alu_out == 8'h00);
          rsp_carry     <= carry_d;
`endif
          // Quiet the ALU inputs outside EXEC.
          alu_opcode    <= 3'd0;
          alu_a         <= 8'h00;
          alu_b         <= 8'h00;
          state_q       <= StResp;
        end
        StResp: begin
          if (rsp_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq with a behavioural external ALU.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [1:0] cmd_dst, cmd_sa, cmd_sb;
  logic [7:0] cmd_imm;
  logic [2:0] alu_opcode;
  logic [7:0] alu_a, alu_b, alu_out;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       rsp_ready;
`ifdef ALU_SEQ_FLAGS_EN
  logic       rsp_zero, rsp_carry;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // External ALU: plus, minus, band, bor, unegate (bitwise invert of a).
  always_comb begin
    alu_out = 8'h00;
    case (alu_opcode)
      3'd0: alu_out = alu_a + alu_b;
      3'd1: alu_out = alu_a - alu_b;
      3'd2: alu_out = alu_a & alu_b;
      3'd3: alu_out = alu_a | alu_b;
      3'd4: alu_out = ~alu_a;
      default: alu_out = 8'h00;
    endcase
  end

  alu_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_dst    (cmd_dst),
    .cmd_sa     (cmd_sa),
    .cmd_sb     (cmd_sb),
    .cmd_imm    (cmd_imm),
    .alu_opcode (alu_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_out    (alu_out),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
`ifdef ALU_SEQ_FLAGS_EN
    .rsp_zero   (rsp_zero),
    .rsp_carry  (rsp_carry),
`endif
    .rsp_ready  (rsp_ready)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete command: accept, optional EXEC cycle, response, release.
  task automatic run(input string tag, input logic [2:0] op, input logic [1:0] dst,
                     input logic [1:0] sa, input logic [1:0] sb, input logic [7:0] imm,
                     input logic [7:0] ea, input logic [7:0] eb,
                     input logic [7:0] ed, input logic ee);
    @(negedge clk);
    cmd_op = op; cmd_dst = dst; cmd_sa = sa; cmd_sb = sb; cmd_imm = imm;
    cmd_valid = 1'b1;
    chk({tag, ".ready"}, {7'd0, cmd_ready}, 8'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (op < 3'd5) begin
      chk({tag, ".exec_vld"}, {7'd0, rsp_valid}, 8'd0);
      chk({tag, ".exec_op"}, {5'd0, alu_opcode}, {5'd0, op});
      chk({tag, ".exec_a"}, alu_a, ea);
      chk({tag, ".exec_b"}, alu_b, eb);
      @(posedge clk); #1;
    end
    chk({tag, ".vld"}, {7'd0, rsp_valid}, 8'd1);
    chk({tag, ".data"}, rsp_data, ed);
    chk({tag, ".err"}, {7'd0, rsp_err}, {7'd0, ee});
    chk({tag, ".alu_quiet"}, alu_a | alu_b | {5'd0, alu_opcode}, 8'd0);
    chk({tag, ".busy"}, {7'd0, cmd_ready}, 8'd0);
`ifdef ALU_SEQ_FLAGS_EN
    begin
      logic [8:0] s;
      logic ez, ec;
      s  = {1'b0, ea} + {1'b0, eb};
      ez = (op != 3'd7) && (ed == 8'h00);
      ec = (op == 3'd0) ? s[8] : (op == 3'd1) ? (ea < eb) : 1'b0;
      chk({tag, ".zero"}, {7'd0, rsp_zero}, {7'd0, ez});
      chk({tag, ".carry"}, {7'd0, rsp_carry}, {7'd0, ec});
    end
`endif
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({tag, ".done"}, {7'd0, rsp_valid}, 8'd0);
    chk({tag, ".idle"}, {7'd0, cmd_ready}, 8'd1);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_op = 3'd0; cmd_dst = 2'd0; cmd_sa = 2'd0; cmd_sb = 2'd0; cmd_imm = 8'h00;

    // Reset state.
    #12;
    chk("rst.ready", {7'd0, cmd_ready}, 8'd1);
    chk("rst.vld", {7'd0, rsp_valid}, 8'd0);
    chk("rst.data", rsp_data, 8'h00);
    chk("rst.err", {7'd0, rsp_err}, 8'd0);
    chk("rst.alu", alu_a | alu_b | {5'd0, alu_opcode}, 8'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Plus wrap: 0F + F1 = 00 with carry.
    run("ld1", 3'd5, 2'd1, 2'd0, 2'd0, 8'h0F, 8'h00, 8'h00, 8'h0F, 1'b0);
    run("ld2", 3'd5, 2'd2, 2'd0, 2'd0, 8'hF1, 8'h00, 8'h00, 8'hF1, 1'b0);
    run("plus", 3'd0, 2'd3, 2'd1, 2'd2, 8'h00, 8'h0F, 8'hF1, 8'h00, 1'b0);
    run("rd3", 3'd6, 2'd0, 2'd3, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);

    // Minus with borrow: 05 - 07 = FE.
    run("ld1b", 3'd5, 2'd1, 2'd0, 2'd0, 8'h05, 8'h00, 8'h00, 8'h05, 1'b0);
    run("ld2b", 3'd5, 2'd2, 2'd0, 2'd0, 8'h07, 8'h00, 8'h00, 8'h07, 1'b0);
    run("minus", 3'd1, 2'd0, 2'd1, 2'd2, 8'h00, 8'h05, 8'h07, 8'hFE, 1'b0);
    run("rd0", 3'd6, 2'd0, 2'd0, 2'd0, 8'h00, 8'h00, 8'h00, 8'hFE, 1'b0);

    // Logic ops on A5 / 3C.
    run("ld1c", 3'd5, 2'd1, 2'd0, 2'd0, 8'hA5, 8'h00, 8'h00, 8'hA5, 1'b0);
    run("ld2c", 3'd5, 2'd2, 2'd0, 2'd0, 8'h3C, 8'h00, 8'h00, 8'h3C, 1'b0);
    run("band", 3'd2, 2'd0, 2'd1, 2'd2, 8'h00, 8'hA5, 8'h3C, 8'h24, 1'b0);
    run("bor", 3'd3, 2'd0, 2'd1, 2'd2, 8'h00, 8'hA5, 8'h3C, 8'hBD, 1'b0);
    run("uneg", 3'd4, 2'd0, 2'd1, 2'd2, 8'h00, 8'hA5, 8'h3C, 8'h5A, 1'b0);

    // Reserved op, then registers untouched.
    run("rsvd", 3'd7, 2'd1, 2'd1, 2'd2, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
    run("rd1", 3'd6, 2'd0, 2'd1, 2'd0, 8'h00, 8'h00, 8'h00, 8'hA5, 1'b0);

    // 255 + 1 wraps; sa = sb = dst reads old value.
    run("ldff", 3'd5, 2'd0, 2'd0, 2'd0, 8'hFF, 8'h00, 8'h00, 8'hFF, 1'b0);
    run("ld01", 3'd5, 2'd3, 2'd0, 2'd0, 8'h01, 8'h00, 8'h00, 8'h01, 1'b0);
    run("wrap", 3'd0, 2'd0, 2'd0, 2'd3, 8'h00, 8'hFF, 8'h01, 8'h00, 1'b0);
    run("self", 3'd0, 2'd1, 2'd1, 2'd1, 8'h00, 8'hA5, 8'hA5, 8'h4A, 1'b0);
    run("rdself", 3'd6, 2'd0, 2'd1, 2'd0, 8'h00, 8'h00, 8'h00, 8'h4A, 1'b0);

    // Backpressure: response held, new command ignored.
    @(negedge clk);
    cmd_op = 3'd5; cmd_dst = 2'd2; cmd_imm = 8'h42; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_imm = 8'h99;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold.vld", {7'd0, rsp_valid}, 8'd1);
      chk("hold.data", rsp_data, 8'h42);
      chk("hold.ready", {7'd0, cmd_ready}, 8'd0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    run("rdhold", 3'd6, 2'd0, 2'd2, 2'd0, 8'h00, 8'h00, 8'h00, 8'h42, 1'b0);

    // Reset in EXEC abandons the plus into R2.
    @(negedge clk);
    cmd_op = 3'd0; cmd_dst = 2'd2; cmd_sa = 2'd1; cmd_sb = 2'd1; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("rx.exec_a", alu_a, 8'h4A);
    rst_n = 1'b0;
    #1;
    chk("rx.vld", {7'd0, rsp_valid}, 8'd0);
    chk("rx.ready", {7'd0, cmd_ready}, 8'd1);
    chk("rx.alu", alu_a | alu_b, 8'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run("rxrd2", 3'd6, 2'd0, 2'd2, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    run("rxrd1", 3'd6, 2'd0, 2'd1, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    run("rxrd3", 3'd6, 2'd0, 2'd3, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have port cmd_valid  input  1  command offered.
REQ-004 SHALL have port cmd_ready  output  1  block can accept a command.
REQ-005 SHALL have port cmd_op  input  3  0 plus, 1 minus, 2 band, 3 bor, 4 unegate, 5 LOAD, 6 READ, 7 reserved.
REQ-006 SHALL have ports cmd_dst, cmd_sa, cmd_sb  input  2 each  destination, operand-A and operand-B register indices.
REQ-007 SHALL have port cmd_imm  input  8  immediate for LOAD.
REQ-008 SHALL have ports alu_opcode  output  3, alu_a  output  8, alu_b  output  8  drive the external ALU.
REQ-009 SHALL have port alu_out  input  8  combinational ALU result.
REQ-010 SHALL have ports rsp_valid  output  1, rsp_data  output  8, rsp_err  output  1  response.
REQ-011 SHALL have port rsp_ready  input  1  response consumer ready.

Function
REQ-012 SHALL hold four 8-bit registers R0..R3.
REQ-013 SHALL implement FSM states IDLE, EXEC, RESP; cmd_ready = 1 only in IDLE.
REQ-014 Command SHALL be accepted on a rising edge with IDLE and cmd_valid = 1; all cmd_* fields latched at that edge.
REQ-015 ALU op (0-4) accepted at edge T: SHALL enter EXEC at T; alu_opcode/alu_a/alu_b driven from registers = op, R[sa], R[sb] throughout EXEC.
REQ-016 At edge T+1 in EXEC: SHALL write alu_out to R[dst], set rsp_data = alu_out, rsp_err = 0, enter RESP; rsp_valid high after T+1.
REQ-017 LOAD: SHALL write cmd_imm to R[dst], rsp_data = cmd_imm, enter RESP directly; rsp_valid high after T.
REQ-018 READ: SHALL set rsp_data = R[sa], no register write, enter RESP directly.
REQ-019 op 7: SHALL set rsp_err = 1, rsp_data = 0, no register write, enter RESP directly.
REQ-020 rsp_valid SHALL equal 1 exactly in RESP; rsp_data/rsp_err SHALL stay stable while rsp_valid = 1 and rsp_ready = 0.
REQ-021 RESP with rsp_ready = 1 at an edge SHALL return to IDLE; next command acceptable one edge later (no back-to-back in same cycle).
REQ-022 Outside EXEC SHALL drive alu_opcode = 0, alu_a = 0, alu_b = 0 so no undefined ALU result propagates.
REQ-023 Arithmetic SHALL be 8-bit modulo (255+1 = 0, 0-1 = 255); sa = sb = dst allowed, operands read before write.

Reset
REQ-024 rst_n low SHALL immediately force IDLE, R0..R3 = 0, rsp_valid = 0, rsp_data = 0, rsp_err = 0, alu_* = 0, cmd_ready = 1 once in IDLE.
REQ-025 Reset during EXEC or RESP SHALL abandon the command: no writeback, no response after release.
REQ-026 First command SHALL be acceptable on the first rising edge after rst_n deasserts.

Configuration
REQ-027 Macro ALU_SEQ_FLAGS_EN defined: SHALL add outputs rsp_zero (1 = rsp_data == 0 on ALU/LOAD/READ) and rsp_carry (carry-out of 9-bit a+b for plus, borrow a<b for minus, 0 otherwise), registered with rsp_data, reset 0.
REQ-028 Macro ALU_SEQ_FLAGS_EN undefined: rsp_zero and rsp_carry ports and logic SHALL be absent; all other behaviour identical.

Verification
REQ-029 Reset, LOAD R1=8'h0F, LOAD R2=8'hF1, op plus dst=3 sa=1 sb=2 -> rsp_data 8'h00 two edges after accept, R3 = 0; with FLAGS rsp_zero = 1, rsp_carry = 1.
REQ-030 R1=8'h05, R2=8'h07, op minus dst=0 -> rsp_data 8'hFE, err 0; with FLAGS rsp_carry = 1.
REQ-031 band/bor/unegate on R1=8'hA5, R2=8'h3C -> 8'h24, 8'hBD, 8'h5A; alu_opcode/alu_a/alu_b nonzero only during the EXEC cycle.
REQ-032 op 7 then READ sa=1 -> first response err 1 data 0; second data 8'hA5 (registers unchanged).
REQ-033 Hold rsp_ready = 0 for 5 cycles in RESP -> rsp_valid/rsp_data stable, cmd_ready = 0, cmd_valid ignored.
REQ-034 Assert rst_n low during EXEC of plus dst=2 -> rsp_valid 0, all registers 0 after release, READ sa=2 returns 8'h00.
